dfg_descrambler: RTL and testbench
==================================

Name: dfg_descrambler

Overview:
- Receive-side, self-synchronising descrambler for a 1-bit serial stream produced by a multiplicative (feedback) scrambler, polynomial x^7+x^6+1 by default.
- The transmitter's feedback loop becomes a feed-forward tap network here, registered once per accepted beat.
- A small acquisition FSM fills the history, then hunts for a run of idle zeros before declaring lock and forwarding data.
- Output stage is a single-register valid/ready slice.

Parameters:
- LEN, 7: history length in bits; s[0] holds the most recently received bit.
- TAP_A, 5: first tap index into s (delay TAP_A+1 beats).
- TAP_B, 6: second tap index into s (delay TAP_B+1 beats); TAP_B < LEN.
- IDLE_RUN, 16: consecutive descrambled zeros required to lock (≥1, ≤255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- resync  in  1  synchronous request to drop lock and reacquire
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  1  scrambled line bit
- out_valid  out  1  descrambled bit valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  1  descrambled bit
- locked  out  1  high while FSM is in LOCK
- drop_cnt  out  16  saturating count of accepted-but-discarded beats

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=FILL, s=0, fill count=0, zero-run count=0, out_valid=0, out_data=0, locked=0, drop_cnt=0.
- Descramble function: d = in_data ^ s[TAP_A] ^ s[TAP_B], computed on the pre-shift s.
- History update: on every accepted beat, s shifts (s[i+1]<=s[i], s[0]<=in_data). The raw line bit is shifted in, never d.
- FILL:
  - in_ready=1; every accepted beat is discarded and drop_cnt increments.
  - After the LEN-th accepted beat, next state is HUNT.
- HUNT:
  - in_ready=1; every accepted beat is discarded and drop_cnt increments.
  - d==0 increments the zero-run count; d==1 clears it to 0.
  - The beat that brings the count to IDLE_RUN is still discarded, and state becomes LOCK on that edge.
- LOCK:
  - in_ready = !out_valid || out_ready.
  - An accepted beat loads out_data<=d and sets out_valid=1 on the next edge (latency 1 cycle).
  - out_valid clears only when it was set, out_ready=1, and no new beat is accepted in the same cycle.
  - out_data and out_valid are held stable while out_valid && !out_ready.
- locked is a registered decode of state==LOCK, so it rises on the same edge that enters LOCK.
- resync=1:
  - Takes priority over any input beat that cycle. in_ready is still 1 and the beat is discarded, but it is neither counted nor shifted.
  - Next edge: state=FILL, s=0, counters=0, out_valid=0, locked=0. drop_cnt is not cleared.
  - Applies in any state, including mid-backpressure; any pending output beat is lost.
- rst mid-operation: identical to reset values, drop_cnt included.
- drop_cnt saturates at 16'hFFFF and does not wrap.
- Lock is never lost spontaneously; only resync or rst leaves LOCK.
- Error property: one flipped line bit at beat k corrupts exactly the outputs at k, k+TAP_A+1 and k+TAP_B+1, then self-heals.

Decomposition:
- Package dfg_descrambler_pkg holds:
  - the state enum (FILL, HUNT, LOCK);
  - default LEN/TAP_A/TAP_B/IDLE_RUN localparams;
  - a function computing d from (in_data, s), also used by the bench's reference scrambler model.
- One sub-module, dfg_descr_core: history register plus tap XOR, with inputs shift_en and clr and output d. It contains no handshake logic.
- The FSM, counters and output slice live in the top-level block.

Test Plan:
- Fill: rst, then 7 accepted beats of random data -> out_valid=0, locked=0, drop_cnt=7, state HUNT.
- Lock: 23 beats of scrambled idle zeros from a scrambler seeded 7'h5A -> locked rises on the edge after beat 23; drop_cnt=23; beat 24 carrying payload 1 gives out_data=1, out_valid=1 one cycle later.
- Hunt reset: descrambled stream 15 zeros, one 1, then 16 zeros after FILL -> lock only after the final zero; drop_cnt=7+32=39.
- Backpressure: in LOCK with out_ready=0 for 5 cycles -> in_ready=0 for cycles 2..5; out_data held; no beat lost; sequence matches the scrambler input exactly.
- Error multiplication: flip line bit 40 while in LOCK -> output mismatches exactly at beats 40, 46, 47; every other beat matches.
- Resync mid-stream: pulse resync with in_valid=1 and out_valid=1 -> next cycle locked=0, out_valid=0, drop_cnt unchanged; relock after a further 7+16 beats.

Source files
------------

// File: rtl/dfg_descrambler_pkg.sv
// Shared types, default parameters and the tap function for the serial descrambler.
// The same tap function drives the receiver here and any reference scrambler model.
package dfg_descrambler_pkg;

    typedef enum logic [1:0] {StFill, StHunt, StLock} state_e;

    localparam int unsigned DefLen     = 7;
    localparam int unsigned DefTapA    = 5;
    localparam int unsigned DefTapB    = 6;
    localparam int unsigned DefIdleRun = 16;

    // Widest history the tap function accepts; narrower histories are zero-extended.
    localparam int unsigned MaxLen = 32;

    function automatic logic tap_xor(input logic              in_bit,
                                     input logic [MaxLen-1:0] hist,
                                     input logic [4:0]        tap_a,
                                     input logic [4:0]        tap_b);
        return in_bit ^ hist[tap_a] ^ hist[tap_b];
    endfunction

endpackage

// File: rtl/dfg_descr_core.sv
// History shift register and feed-forward tap XOR. The raw line bit is shifted in,
// so the receiver resynchronises on its own after LEN beats.
module dfg_descr_core
    import dfg_descrambler_pkg::*;
#(
    parameter int unsigned LEN   = DefLen,
    parameter int unsigned TAP_A = DefTapA,
    parameter int unsigned TAP_B = DefTapB
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift_en,
    input  logic in_data,
    output logic d
);

    localparam logic [4:0] TapASel = 5'(TAP_A);
    localparam logic [4:0] TapBSel = 5'(TAP_B);

    logic [LEN-1:0] s_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s_q <= '0;
        end else if (shift_en) begin
            s_q <= {s_q[LEN-2:0], in_data};
        end
    end

    // Taps read the pre-shift history.
    assign d = tap_xor(in_data, MaxLen'(s_q), TapASel, TapBSel);

endmodule

// File: rtl/dfg_descrambler.sv
// Self-synchronising descrambler with fill/hunt/lock acquisition and a one-entry
// valid/ready output register.
module dfg_descrambler
    import dfg_descrambler_pkg::*;
#(
    parameter int unsigned LEN      = DefLen,
    parameter int unsigned TAP_A    = DefTapA,
    parameter int unsigned TAP_B    = DefTapB,
    parameter int unsigned IDLE_RUN = DefIdleRun
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resync,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_data,
    output logic        locked,
    output logic [15:0] drop_cnt
);

    localparam int unsigned FillW = $clog2(LEN + 1);

    state_e            state_q, state_d;
    logic [FillW-1:0]  fill_cnt_q;
    logic [7:0]        run_cnt_q;
    logic [15:0]       drop_cnt_q;
    logic              out_valid_q, out_data_q, locked_q;
    logic              d, shift_en;

    dfg_descr_core #(
        .LEN   (LEN),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (resync),
        .shift_en (shift_en),
        .in_data  (in_data),
        .d        (d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFill;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            locked_q <= (state_d == StLock);
        end
    end

    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = StFill;
        end else if (shift_en) begin
            case (state_q)
                StFill:  if (fill_cnt_q == FillW'(LEN - 1)) state_d = StHunt;
                StHunt:  if (!d && run_cnt_q == 8'(IDLE_RUN - 1)) state_d = StLock;
                default: state_d = state_q;
            endcase
        end
    end

    // A resync beat is always taken off the line, even under backpressure, but never used.
    always_comb begin
        in_ready = 1'b1;
        if (state_q == StLock && !resync) in_ready = !out_valid_q || out_ready;
        shift_en = in_valid && in_ready && !resync;
    end

    always_ff @(posedge clk) begin
        if (rst || resync) begin
            fill_cnt_q <= '0;
            run_cnt_q  <= '0;
        end else if (shift_en) begin
            if (state_q == StFill) fill_cnt_q <= fill_cnt_q + 1'b1;
            if (state_q == StHunt) run_cnt_q <= d ? 8'd0 : run_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (shift_en && state_q != StLock && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
        end else if (resync) begin
            out_valid_q <= 1'b0;
        end else if (state_q == StLock && shift_en) begin
            out_valid_q <= 1'b1;
            out_data_q  <= d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign locked    = locked_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_dfg_descrambler.sv
// Directed bench for dfg_descrambler: a reference scrambler drives the line, and a
// line-history model predicts every output on each cycle.
module tb_dfg_descrambler;
    import dfg_descrambler_pkg::*;

    logic        clk = 1'b0;
    logic        rst, resync, in_valid, in_ready, in_data;
    logic        out_valid, out_ready, out_data, locked;
    logic [15:0] drop_cnt;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] tx_t;
    logic        rdy_mode = 1'b1;
    logic        out_log[$];

    // Model state: line bits since the last clear, acquisition phase 0/1/2 = fill/hunt/lock.
    logic        line[$];
    int          m_phase, m_run;
    logic        m_ov, m_od, m_lock;
    logic [15:0] m_drop;
    bit          m_valid = 1'b0;

    dfg_descrambler u_dut (
        .clk       (clk),
        .rst       (rst),
        .resync    (resync),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .locked    (locked),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Compare DUT against the model, then advance the model with the inputs about to be sampled.
    initial begin : model
        logic mrdy, acc, dd;
        int   n;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                mrdy = resync || m_phase != 2 || !m_ov || out_ready;
                check("in_ready", in_ready, mrdy);
                check("locked", locked, m_lock);
                check("out_valid", out_valid, m_ov);
                check("drop_cnt", drop_cnt, m_drop);
                if (m_ov) check("out_data", out_data, m_od);
                if (out_valid && out_ready) out_log.push_back(out_data);
            end
            if (rst) begin
                line.delete();
                m_phase = 0; m_run = 0; m_ov = 0; m_od = 0; m_lock = 0; m_drop = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                mrdy = resync || m_phase != 2 || !m_ov || out_ready;
                acc  = in_valid && mrdy;
                if (resync) begin
                    line.delete();
                    m_phase = 0; m_run = 0; m_ov = 0; m_lock = 0;
                end else if (acc) begin
                    n  = line.size();
                    dd = in_data ^ (n >= 6 ? line[n-6] : 1'b0) ^ (n >= 7 ? line[n-7] : 1'b0);
                    if (m_phase != 2 && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                    if (m_phase == 2) begin
                        m_ov = 1'b1;
                        m_od = dd;
                    end else if (m_phase == 1) begin
                        m_run = dd ? 0 : m_run + 1;
                        if (m_run == 16) begin
                            m_phase = 2;
                            m_lock  = 1'b1;
                        end
                    end
                    line.push_back(in_data);
                    if (m_phase == 0 && line.size() == 7) m_phase = 1;
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    end

    // One cycle of stimulus; the scrambler advances only when the beat is taken.
    task automatic drive(input logic v, input logic p, input logic rdy, input logic rs,
                         input logic flip, output logic acc);
        logic c;
        c = tap_xor(p, tx_t, 5'd5, 5'd6);
        in_valid  = v;
        in_data   = c ^ flip;
        out_ready = rdy;
        resync    = rs;
        @(negedge clk);
        acc = v && in_ready;
        @(posedge clk);
        #1;
        if (acc) tx_t = {tx_t[30:0], c};
        in_valid = 1'b0;
        resync   = 1'b0;
    endtask

    task automatic send(input logic p, input logic flip);
        logic acc;
        int   n;
        n = 0;
        do begin
            drive(1'b1, p, rdy_mode, 1'b0, flip, acc);
            n++;
        end while (!acc && n < 40);
        check("send_accept", acc, 1);
    endtask

    task automatic drain();
        logic acc;
        repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic        bp[8];
        logic        pay[60];
        logic [63:0] mask;
        logic [15:0] drop_before;

        rst = 1'b1; resync = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
        tx_t = 32'h0;
        @(posedge clk);
        #1;

        // Fill
        do_reset();
        check("rst_locked", locked, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        for (int i = 0; i < 7; i++) send(1'($urandom), 1'b0);
        check("fill_drop", drop_cnt, 7);
        check("fill_locked", locked, 0);
        check("fill_out_valid", out_valid, 0);

        // Lock from scrambled idle
        do_reset();
        tx_t = 32'h5A;
        for (int i = 0; i < 22; i++) send(1'b0, 1'b0);
        check("lock_early", locked, 0);
        send(1'b0, 1'b0);
        check("lock_rise", locked, 1);
        check("lock_drop", drop_cnt, 23);
        check("lock_no_out", out_valid, 0);
        send(1'b1, 1'b0);
        check("first_out_valid", out_valid, 1);
        check("first_out_data", out_data, 1);

        // Hunt run reset by a single one
        do_reset();
        tx_t = 32'h13;
        for (int i = 0; i < 7; i++) send(1'($urandom), 1'b0);
        for (int i = 0; i < 15; i++) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) send(1'b0, 1'b0);
        check("hunt_no_lock", locked, 0);
        send(1'b0, 1'b0);
        check("hunt_lock", locked, 1);
        check("hunt_drop", drop_cnt, 39);

        // Backpressure
        out_log.delete();
        bp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        drive(1'b1, bp[0], 1'b0, 1'b0, 1'b0, acc);
        check("bp_c1_ready", acc, 1);
        for (int k = 1; k < 5; k++) begin
            drive(1'b1, bp[1], 1'b0, 1'b0, 1'b0, acc);
            check("bp_stall_ready", acc, 0);
        end
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, bp[0]);
        for (int i = 1; i < 8; i++) send(bp[i], 1'b0);
        drain();
        check("bp_count", out_log.size(), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) check("bp_seq", out_log[i], bp[i]);

        // Single line error multiplies to three outputs
        out_log.delete();
        for (int i = 0; i < 60; i++) begin
            pay[i] = 1'($urandom);
            send(pay[i], i == 40);
        end
        drain();
        check("err_count", out_log.size(), 60);
        mask = '0;
        for (int i = 0; i < 60 && i < out_log.size(); i++) if (out_log[i] !== pay[i]) mask[i] = 1'b1;
        check("err_positions", mask, (64'd1 << 40) | (64'd1 << 46) | (64'd1 << 47));

        // Resync with a pending output beat
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check("rs_pending", out_valid, 1);
        drop_before = drop_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        check("rs_in_ready", acc, 1);
        check("rs_locked", locked, 0);
        check("rs_out_valid", out_valid, 0);
        check("rs_drop_kept", drop_cnt, drop_before);
        for (int i = 0; i < 22; i++) send(1'b0, 1'b0);
        check("relock_early", locked, 0);
        send(1'b0, 1'b0);
        check("relock", locked, 1);
        check("relock_drop", drop_cnt, drop_before + 16'd23);

        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
